// File: rtl/maze_player.sv
// maze_player: steps a player through a generated maze read back from the maze RAM.
// Define MAZE_PLAYER_MOVE_COUNT_EN to enable the saturating successful-move counter.
module maze_player #(
  parameter int WIDTH        = 30,
  parameter int HEIGHT       = 40,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        maze_ready,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [10:0] maze_address,
  input  logic        maze_address_data,
  output logic [5:0]  player_x,
  output logic [5:0]  player_y,
  output logic        bump,
  output logic        win,
  output logic [15:0] move_count
);

  localparam logic [5:0]  X_MAX      = 6'(WIDTH - 1);
  localparam logic [5:0]  Y_MAX      = 6'(HEIGHT - 1);
  localparam logic [10:0] ROW_STRIDE = 11'(WIDTH);
  localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY - 2);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;

  typedef enum logic [2:0] {IDLE, READY, CHECK, READ, DECIDE, WON} state_t;

  state_t     state_reg, state_next;
  logic [5:0] x_reg, x_next, y_reg, y_next;
  logic [5:0] tx_reg, tx_next, ty_reg, ty_next;
  logic [1:0] dir_reg, dir_next;
  logic [1:0] lat_reg, lat_next;
  logic       bump_reg, bump_next;
  logic       out_of_bounds;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= 6'd0;
      y_reg     <= 6'd0;
      tx_reg    <= 6'd0;
      ty_reg    <= 6'd0;
      dir_reg   <= 2'd0;
      lat_reg   <= 2'd0;
      bump_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      tx_reg    <= tx_next;
      ty_reg    <= ty_next;
      dir_reg   <= dir_next;
      lat_reg   <= lat_next;
      bump_reg  <= bump_next;
    end
  end

  // Edge test on the unchanged position, so no coordinate is ever stepped past a border.
  always_comb begin
    out_of_bounds = 1'b0;
    case (dir_reg)
      DIR_UP:    out_of_bounds = (y_reg == 6'd0);
      DIR_RIGHT: out_of_bounds = (x_reg == X_MAX);
      DIR_DOWN:  out_of_bounds = (y_reg == Y_MAX);
      default:   out_of_bounds = (x_reg == 6'd0);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    tx_next    = tx_reg;
    ty_next    = ty_reg;
    dir_next   = dir_reg;
    lat_next   = lat_reg;
    bump_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (maze_ready) state_next = READY;
      end
      READY: begin
        if (move_valid) begin
          dir_next   = move_dir;
          state_next = CHECK;
          // An edge-bound request leaves the target on the current tile.
          case (move_dir)
            DIR_UP:    if (y_reg != 6'd0)  ty_next = y_reg - 6'd1;
            DIR_RIGHT: if (x_reg != X_MAX) tx_next = x_reg + 6'd1;
            DIR_DOWN:  if (y_reg != Y_MAX) ty_next = y_reg + 6'd1;
            default:   if (x_reg != 6'd0)  tx_next = x_reg - 6'd1;
          endcase
        end
      end
      CHECK: begin
        if (out_of_bounds) begin
          bump_next  = 1'b1;
          state_next = READY;
        end else begin
          lat_next   = 2'd0;
          state_next = (READ_LATENCY > 1) ? READ : DECIDE;
        end
      end
      READ: begin
        if (lat_reg == LAT_LAST) state_next = DECIDE;
        else                     lat_next   = lat_reg + 2'd1;
      end
      DECIDE: begin
        if (!maze_address_data) begin
          x_next     = tx_reg;
          y_next     = ty_reg;
          state_next = (ty_reg == Y_MAX) ? WON : READY;
        end else begin
          bump_next  = 1'b1;
          tx_next    = x_reg;
          ty_next    = y_reg;
          state_next = READY;
        end
      end
      WON: begin
        state_next = WON;
      end
      default: state_next = IDLE;
    endcase
  end

  assign maze_address = ({5'd0, ty_reg} * ROW_STRIDE) + {5'd0, tx_reg};
  assign move_ready   = (state_reg == READY);
  assign win          = (state_reg == WON);
  assign bump         = bump_reg;
  assign player_x     = x_reg;
  assign player_y     = y_reg;

`ifdef MAZE_PLAYER_MOVE_COUNT_EN
  logic [15:0] count_reg, count_next;
  logic        count_inc;

  assign count_inc = (state_reg == DECIDE) && !maze_address_data;

  always_comb begin
    count_next = count_reg;
    if (count_inc && (count_reg != 16'hFFFF)) count_next = count_reg + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_reg <= 16'd0;
    else       count_reg <= count_next;
  end

  assign move_count = count_reg;
`else
  assign move_count = 16'd0;
`endif

endmodule

// File: tb/tb_maze_player.sv
// tb_maze_player: random and directed moves against a tile-level maze model with scoreboard.
`timescale 1ns/1ps
module tb_maze_player;
  localparam int W  = 30;
  localparam int H  = 40;
  localparam int RL = 2;
`ifdef MAZE_PLAYER_MOVE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        maze_ready = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [10:0] maze_address;
  logic        maze_address_data;
  logic [5:0]  player_x, player_y;
  logic        bump, win;
  logic [15:0] move_count;

  maze_player #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .maze_ready(maze_ready),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .maze_address(maze_address), .maze_address_data(maze_address_data),
    .player_x(player_x), .player_y(player_y), .bump(bump), .win(win),
    .move_count(move_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Maze RAM: one bit per tile, data appears RL cycles after the address.
  bit          maze_mem [2048];
  logic [10:0] pipe [RL];
  always @(posedge clock) begin
    pipe[0] <= maze_address;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign maze_address_data = maze_mem[pipe[RL-1]];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endfunction

  typedef struct {
    int x; int y; bit bmp; bit wn; int cnt; int lat; int issue;
  } exp_t;
  exp_t sb[$];

  int mx, my, mcnt;
  bit mwon;

  task automatic model_reset();
    mx = 0; my = 0; mcnt = 0; mwon = 0;
  endtask

  // Tile-level rules: step, reject if off the board or onto a wall.
  task automatic model_move(input logic [1:0] d, output exp_t e, output int addr);
    int nx, ny;
    nx = mx; ny = my;
    e.bmp = 0;
    case (d)
      2'd0: ny = ny - 1;
      2'd1: nx = nx + 1;
      2'd2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
      e.bmp = 1; e.lat = 2; addr = my * W + mx;
    end else begin
      e.lat = 2 + RL; addr = ny * W + nx;
      if (maze_mem[ny * W + nx]) e.bmp = 1;
      else begin
        mx = nx; my = ny;
        if (mcnt < 65535) mcnt = mcnt + 1;
        if (ny == H - 1) mwon = 1;
      end
    end
    e.x = mx; e.y = my; e.wn = mwon; e.cnt = CNT_EN ? mcnt : 0; e.issue = 0;
  endtask

  // Monitor: a move completes when move_ready returns or win rises.
  bit ready_prev = 0, win_prev = 0, bump_prev = 0;
  int ntx = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (bump_prev) chk("bump_width", bump, 0);
      if (((move_ready && !ready_prev) || (win && !win_prev)) && sb.size() > 0) begin
        e = sb.pop_front();
        ntx++;
        $display("move %0d: pos (%0d,%0d) bump %0d win %0d count %0d lat %0d",
                 ntx, player_x, player_y, bump, win, move_count, cyc - e.issue);
        chk("latency", cyc - e.issue, e.lat);
        chk("player_x", player_x, e.x);
        chk("player_y", player_y, e.y);
        chk("bump", bump, e.bmp);
        chk("win", win, e.wn);
        chk("move_count", move_count, e.cnt);
      end
    end
    ready_prev = move_ready;
    win_prev   = win;
    bump_prev  = bump;
  end

  task automatic do_move(input logic [1:0] d);
    int n, a;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!move_ready && n < 200) begin @(negedge clock); n++; end
    if (!move_ready) begin chk("ready_timeout", 0, 1); return; end
    model_move(d, e, a);
    e.issue = cyc;
    move_valid = 1'b1; move_dir = d;
    @(posedge clock); #1;
    sb.push_back(e);
    move_valid = 1'b0; move_dir = 2'($urandom);
    @(negedge clock);
    chk("addr_cycle1", maze_address, a);
  endtask

  task automatic wait_settle();
    int n;
    n = 0;
    while ((sb.size() > 0 || !move_ready) && n < 100) begin @(negedge clock); n++; end
    chk("settle_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; move_valid = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("rst_win", win, 0);
    chk("rst_count", move_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < W * H; i++) maze_mem[i] = ($urandom_range(0, 99) < 30);
    for (int i = W * H; i < 2048; i++) maze_mem[i] = 1'b1;
    for (int x = 0; x < W; x++) maze_mem[x] = 1'b0;
    for (int y = 0; y < H; y++) maze_mem[y * W + 28] = 1'b0;
    maze_mem[1 * W + 1] = 1'b1;
    model_reset();

    // Reset values and the IDLE wait for the generator.
    #1;
    chk("rst_ready", move_ready, 0);
    chk("rst_x", player_x, 0);
    chk("rst_y", player_y, 0);
    chk("rst_bump", bump, 0);
    chk("rst_win", win, 0);
    chk("rst_addr", maze_address, 0);
    chk("rst_count", move_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ready", move_ready, 0);
      chk("idle_pos", {player_y, player_x}, 0);
    end
    @(posedge clock); #1 maze_ready = 1'b1;
    @(posedge clock); #1 maze_ready = 1'b0;
    @(negedge clock);
    chk("ready_after_maze_ready", move_ready, 1);

    // Edges at the origin, a floor step, then a wall below.
    do_move(2'd0);
    do_move(2'd3);
    do_move(2'd1);
    do_move(2'd2);
    wait_settle();

    for (int i = 0; i < 200 && !mwon; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_move(2'($urandom_range(0, 3)));
    end
    wait_settle();

    // Reset mid-read after three successful moves.
    maze_ready = 1'b1;
    do_reset();
    repeat (3) do_move(2'd1);
    wait_settle();
    chk("count_before_reset", move_count, CNT_EN ? 3 : 0);
    do_move(2'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("abort_ready", move_ready, 0);
    chk("abort_x", player_x, 0);
    chk("abort_y", player_y, 0);
    chk("abort_bump", bump, 0);
    chk("abort_addr", maze_address, 0);
    chk("abort_count", move_count, 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Walk to (28,38) and win on the last row.
    repeat (28) do_move(2'd1);
    repeat (38) do_move(2'd2);
    wait_settle();
    chk("pre_win_pos", {26'd0, player_y, player_x}, (38 << 6) | 28);
    do_move(2'd2);
    for (int n = 0; n < 20 && !win; n++) @(negedge clock);
    chk("won_y", player_y, H - 1);
    chk("won_flag", win, 1);
    move_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      move_dir = 2'($urandom);
      @(negedge clock);
      chk("won_ready", move_ready, 0);
      chk("won_pos", {player_y, player_x}, ((H - 1) << 6) | 28);
      chk("won_sticky", win, 1);
    end
    move_valid = 1'b0;
    chk("sb_drain", sb.size(), 0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_player.md
# maze_player

Player-movement controller that reads the generated maze back out of the maze RAM read port (maze_address / maze_address_data) after generation completes. It accepts one direction request at a time over a valid/ready handshake and bounds-checks the target tile. It reads the target tile with a fixed RAM read latency, moves the player only onto FLOOR tiles, and flags a win on reaching the bottom row.

## Interface
- WIDTH, 30, maze columns; must match the maze generator.
- HEIGHT, 40, maze rows; must match the maze generator.
- READ_LATENCY, 2, cycles from maze_address change to valid maze_address_data (1..3).
- clock  input  1  system clock; reset reset, asynchronous, active-high; clock clock.
- reset  input  1  asynchronous, active-high; returns all state to IDLE.
- maze_ready  input  1  generator finished (gen_end); sampled only in IDLE.
- move_valid  input  1  move request present.
- move_dir  input  2  00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- move_ready  output  1  block can accept a move this cycle.
- maze_address  output  11  RAM read address = y*WIDTH + x of the tile being examined.
- maze_address_data  input  1  tile value: 0 FLOOR, 1 WALL.
- player_x  output  6  current column.
- player_y  output  6  current row.
- bump  output  1  one-cycle pulse when a move is rejected (wall or out of bounds).
- win  output  1  sticky; player reached row HEIGHT-1.
- move_count  output  16  successful moves (see Configuration).

## Operation
- States: IDLE, READY, CHECK, READ, DECIDE, WON.
- IDLE: move_ready=0. Exits to READY on the first cycle maze_ready=1.
- READY: move_ready=1. On move_valid&&move_ready, registers the target (tx,ty) from move_dir, then goes to CHECK.
- CHECK: move_ready=0. Out of bounds when: up with y==0; left with x==0; right with x==WIDTH-1; down with y==HEIGHT-1. Out of bounds pulses bump and returns to READY. Otherwise goes to READ with the latency counter cleared.
- Bounds are decided by comparison before any add/subtract. Coordinates never wrap.
- READ: holds maze_address at the target. Counts READ_LATENCY-1 cycles, then goes to DECIDE.
- DECIDE: samples maze_address_data.
  - FLOOR: player_x/y take tx/ty. If ty==HEIGHT-1, sets win and goes to WON; otherwise goes to READY.
  - WALL: pulses bump, leaves the position unchanged, goes to READY.
- WON: move_ready=0 and win=1 until reset; all move requests are ignored.
- Address: maze_address is combinational from the target registers. Outside CHECK/READ/DECIDE the target equals the current position, so the address is y*WIDTH+x. Width is 11 bits, with WIDTH*HEIGHT ≤ 2048.
- Start position is (0,0); row 0 is all FLOOR by construction.
- move_dir is ignored while move_valid=0. move_dir is captured only at the handshake.
- Changes to maze_ready after leaving IDLE are ignored. Regenerating the maze requires asserting reset.

## Timing
- Reset values: move_ready=0, player_x=0, player_y=0, bump=0, win=0, maze_address=0, move_count=0.
- Handshake in cycle 0. maze_address shows the target from cycle 1.
- Out of bounds: bump=1 in cycle 2; move_ready=1 in cycle 2.
- In-bounds move: DECIDE occurs in cycle 1+READ_LATENCY. Position, win, bump and move_count update visibly in cycle 2+READ_LATENCY (cycle 4 at the default). move_ready returns to 1 in the same cycle unless the move won.
- Back-to-back moves: the maximum rate is one move per 2+READ_LATENCY cycles.
- bump is exactly one cycle wide.
- Reset asserted mid-move aborts immediately to IDLE with all reset values; no partial position update.

## Configuration
- MAZE_PLAYER_MOVE_COUNT_EN defined: move_count increments by 1 on each successful (FLOOR) move, saturating at 16'hFFFF. Rejected moves do not count.
- Not defined: no counter logic; move_count is tied to 0.

## Test plan
- Reset, maze_ready=0 for 10 cycles -> move_ready stays 0 and position stays (0,0). Raise maze_ready -> move_ready=1 next cycle.
- At (0,0), request up, then left -> bump pulse in cycle 2 for each; position remains (0,0); no RAM-dependent delay.
- RAM model with RL=2, tile (1,0) FLOOR, request right -> maze_address=1 from cycle 1; player_x=1 in cycle 4; move_ready=1 in cycle 4.
- Tile (1,1) (address 31) WALL, from (1,0) request down -> bump in cycle 4; position unchanged; move_count unchanged.
- Path ending at (28,38) with (28,39) FLOOR, request down -> player_y=39 and win=1 in cycle 4. Subsequent move_valid ignored with move_ready=0. Reset clears win.
- Reset asserted during READ -> outputs return to reset values asynchronously. With the macro defined, the count of 3 prior successful moves reads 3 before reset and 0 after.
